// File: rtl/sdram_test_master.sv
// rtl/sdram_test_master.sv - Avalon-MM pattern write/read-back tester for the SDRAM controller
module sdram_test_master #(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 7
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [DATA_W-1:0] seed,
    output logic              chipselect,
    output logic              write_n,
    output logic              read_n,
    output logic [1:0]        byteenable_n,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    input  logic              wait_request,
    input  logic              data_validation,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic              proto_err
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [3:0] MAX_P = 4'(MAX_PENDING);

    state_t            state;
    logic [ADDR_W-1:0] base_r, len_r, wr_cnt, rd_cnt, ret_cnt;
    logic [DATA_W-1:0] seed_r;
    logic [3:0]        pending;

    logic              wr_acc, rd_acc, dv_counted, mismatch;
    logic [3:0]        pending_next;
    logic [ADDR_W-1:0] wr_next, rd_next, ret_addr;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] s);
        return DATA_W'(a[15:0]) ^ s;
    endfunction

    assign byteenable_n = 2'b00;
    assign pass         = done & (err_count == 16'h0) & ~proto_err;

    assign wr_acc       = chipselect & ~write_n & ~wait_request;
    assign rd_acc       = chipselect & ~read_n & ~wait_request;
    // A return with nothing outstanding is a protocol error, never a compare
    assign dv_counted   = data_validation & (pending != 4'd0);
    assign pending_next = pending + 4'(rd_acc) - 4'(dv_counted);
    assign wr_next      = wr_cnt + ADDR_W'(1);
    assign rd_next      = rd_cnt + ADDR_W'(1);
    assign ret_addr     = base_r + ret_cnt;
    assign mismatch     = read_data != pattern(ret_addr, seed_r);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            chipselect      <= 1'b0;
            write_n         <= 1'b1;
            read_n          <= 1'b1;
            address         <= '0;
            write_data      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= 16'h0;
            first_fail_addr <= '0;
            proto_err       <= 1'b0;
            pending         <= 4'd0;
            base_r          <= '0;
            len_r           <= '0;
            seed_r          <= '0;
            wr_cnt          <= '0;
            rd_cnt          <= '0;
            ret_cnt         <= '0;
        end else begin
            pending <= pending_next;
            if (data_validation && pending == 4'd0)
                proto_err <= 1'b1;
            if (dv_counted) begin
                ret_cnt <= ret_cnt + ADDR_W'(1);
                if (mismatch) begin
                    if (err_count != 16'hFFFF)
                        err_count <= err_count + 16'h1;
                    if (err_count == 16'h0)
                        first_fail_addr <= ret_addr;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        base_r          <= base_addr;
                        len_r           <= length;
                        seed_r          <= seed;
                        wr_cnt          <= '0;
                        rd_cnt          <= '0;
                        ret_cnt         <= '0;
                        err_count       <= 16'h0;
                        first_fail_addr <= '0;
                        proto_err       <= 1'b0;
                        done            <= 1'b0;
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= WRITE;
                            busy       <= 1'b1;
                            chipselect <= 1'b1;
                            write_n    <= 1'b0;
                            address    <= base_addr;
                            write_data <= pattern(base_addr, seed);
                        end
                    end
                end
                WRITE: begin
                    if (wr_acc) begin
                        wr_cnt <= wr_next;
                        if (wr_next == len_r) begin
                            state   <= READ;
                            write_n <= 1'b1;
                            read_n  <= 1'b0;
                            address <= base_r;
                        end else begin
                            address    <= base_r + wr_next;
                            write_data <= pattern(base_r + wr_next, seed_r);
                        end
                    end
                end
                READ: begin
                    // A read is only presented when its acceptance cannot exceed MAX_PENDING
                    if (rd_acc) begin
                        rd_cnt <= rd_next;
                        if (rd_next == len_r) begin
                            state      <= DRAIN;
                            chipselect <= 1'b0;
                            read_n     <= 1'b1;
                        end else if (pending_next < MAX_P) begin
                            address <= base_r + rd_next;
                        end else begin
                            chipselect <= 1'b0;
                            read_n     <= 1'b1;
                        end
                    end else if (!chipselect && pending_next < MAX_P) begin
                        chipselect <= 1'b1;
                        read_n     <= 1'b0;
                        address    <= base_r + rd_cnt;
                    end
                end
                DRAIN: begin
                    if (pending == 4'd0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_test_master.sv
// tb/tb_sdram_test_master.sv - directed bench with a behavioural SDRAM slave
module tb_sdram_test_master;
    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [24:0] base_addr = '0;
    logic [24:0] length = '0;
    logic [15:0] seed = '0;
    logic        chipselect, write_n, read_n;
    logic [1:0]  byteenable_n;
    logic [24:0] address;
    logic [15:0] write_data;
    logic [15:0] read_data = '0;
    logic        wait_request = 1'b0;
    logic        data_validation = 1'b0;
    logic        busy, done, pass, proto_err;
    logic [15:0] err_count;
    logic [24:0] first_fail_addr;

    int errors = 0;
    int checks = 0;

    sdram_test_master dut (
        .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .length(length), .seed(seed), .chipselect(chipselect), .write_n(write_n),
        .read_n(read_n), .byteenable_n(byteenable_n), .address(address),
        .write_data(write_data), .read_data(read_data), .wait_request(wait_request),
        .data_validation(data_validation), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_addr(first_fail_addr), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    // Slave model: decides wait_request/returns on the falling edge for the next rising edge
    typedef struct { int due; logic [15:0] d; } ret_t;
    ret_t        rq[$];
    logic [15:0] mem [int];
    int cyc = 0, lat = 2, corrupt_addr = -1, stall_addr = -1;
    int stall_cnt = 0, hold_seen = 0, hold_bad = 0;
    int wr_total = 0, rd_total = 0, dv_total = 0, max_out = 0;
    int stray_req = 0, stray_done = 0;

    always @(negedge clock) begin
        cyc++;
        data_validation = 1'b0;
        read_data = 16'h0;
        if (stray_req != stray_done) begin
            data_validation = 1'b1;
            read_data = 16'h5555;
            stray_done++;
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            data_validation = 1'b1;
            read_data = rq[0].d;
            void'(rq.pop_front());
            dv_total++;
        end
        wait_request = 1'b0;
        if (chipselect && !write_n && int'(address) == stall_addr) begin
            hold_seen++;
            if (write_data != 16'hA4A4) hold_bad++;
            if (stall_cnt < 3) begin
                wait_request = 1'b1;
                stall_cnt++;
            end
        end
        if (chipselect && !wait_request) begin
            if (!write_n) begin
                mem[int'(address)] = write_data;
                wr_total++;
            end else if (!read_n) begin
                rq.push_back('{cyc + lat,
                    (int'(address) == corrupt_addr) ? 16'hFFFF : mem[int'(address)]});
                rd_total++;
            end
        end
        if (rd_total - dv_total > max_out) max_out = rd_total - dv_total;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [24:0] b, input logic [24:0] n, input logic [15:0] s);
        @(negedge clock);
        base_addr = b;
        length = n;
        seed = s;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    int wr0, rd0;

    initial begin
        #3 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        check("rst_cs", 32'(chipselect), 32'd0);
        check("rst_cmd", 32'({write_n, read_n, byteenable_n}), 32'b1100);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_stat", 32'({busy, done, pass, proto_err}), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);

        stray_req++;
        repeat (3) @(negedge clock);
        check("stray_proto", 32'(proto_err), 32'd1);

        // Ideal slave, base 0, identity pattern
        wr0 = wr_total; rd0 = rd_total;
        run(25'h0, 25'd4, 16'h0000);
        check("t1_first_cmd", 32'({busy, chipselect, write_n}), 32'b110);
        check("t1_first_addr", 32'(address), 32'd0);
        wait_done("t1_done");
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_err", 32'(err_count), 32'd0);
        check("t1_proto_clr", 32'(proto_err), 32'd0);
        check("t1_mem3", 32'(mem[3]), 32'h0003);
        check("t1_writes", 32'(wr_total - wr0), 32'd4);
        check("t1_reads", 32'(rd_total - rd0), 32'd4);

        // Three-cycle stall on the second write
        stall_addr = 25'h101;
        wr0 = wr_total;
        run(25'h100, 25'd4, 16'hA5A5);
        wait_done("t2_done");
        check("t2_hold_seen", 32'(hold_seen), 32'd4);
        check("t2_hold_bad", 32'(hold_bad), 32'd0);
        check("t2_writes", 32'(wr_total - wr0), 32'd4);
        check("t2_mem101", 32'(mem[32'h101]), 32'hA4A4);
        check("t2_mem100", 32'(mem[32'h100]), 32'hA4A5);
        check("t2_pass", 32'(pass), 32'd1);

        // Corrupt read at address 2
        corrupt_addr = 2;
        run(25'h0, 25'd8, 16'h0F0F);
        wait_done("t3_done");
        check("t3_err", 32'(err_count), 32'd1);
        check("t3_ffa", 32'(first_fail_addr), 32'd2);
        check("t3_pass", 32'(pass), 32'd0);
        corrupt_addr = -1;

        // Long read latency exercises the outstanding limit
        lat = 10;
        rd0 = rd_total;
        run(25'h40, 25'd20, 16'h3C3C);
        wait_done("t4_done");
        check("t4_max_out", 32'(max_out), 32'd7);
        check("t4_reads", 32'(rd_total - rd0), 32'd20);
        check("t4_err", 32'(err_count), 32'd0);
        check("t4_pass", 32'(pass), 32'd1);
        lat = 2;

        // Address wrap at the top of memory
        run(25'h1FFFFFE, 25'd4, 16'h1234);
        wait_done("t5_done");
        check("t5_mem_fffe", 32'(mem[32'h1FFFFFE]), 32'hEDCA);
        check("t5_mem_ffff", 32'(mem[32'h1FFFFFF]), 32'hEDCB);
        check("t5_mem0", 32'(mem[0]), 32'h1234);
        check("t5_mem1", 32'(mem[1]), 32'h1235);
        check("t5_pass", 32'(pass), 32'd1);

        // Empty test
        wr0 = wr_total; rd0 = rd_total;
        run(25'h55, 25'd0, 16'hBEEF);
        check("t6_done", 32'({done, pass, busy}), 32'b110);
        check("t6_no_cmds", 32'((wr_total - wr0) + (rd_total - rd0)), 32'd0);

        // Reset in the middle of the read phase
        lat = 10;
        run(25'h0, 25'd20, 16'h0000);
        begin
            int n = 0;
            while (read_n && n < 500) begin
                @(negedge clock);
                n++;
            end
        end
        check("t6_in_read", 32'(read_n), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_cmd", 32'({chipselect, write_n, read_n, byteenable_n}), 32'b01100);
        check("t6_rst_addr", 32'({address, write_data}), 32'd0);
        check("t6_rst_stat", 32'({busy, done, pass, proto_err}), 32'd0);
        check("t6_rst_err", 32'({err_count, first_fail_addr}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sdram_test_master.md
Name: sdram_test_master

Overview:
- Avalon-MM initiator that drives the SDRAM controller's slave port.
- On a start pulse it:
  - writes a seeded pattern to a contiguous word range;
  - reads the range back with pipelined reads;
  - compares the returned data and reports pass/fail, error count and first failing address.
- Sits between the lab top-level (switches/keys/HEX display) and the SDRAM controller.
- Serves as the bring-up and soak test for the SDRAM path.

Parameters:
- ADDR_W, 25, word-address width; matches the controller address port.
- DATA_W, 16, data width; matches the controller data ports.
- MAX_PENDING, 7, maximum reads accepted but not yet returned (1..15).

Ports:
- clock  in  1  system clock, same clock as the SDRAM controller.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a test when in IDLE, ignored otherwise.
- base_addr  in  ADDR_W  first word address; latched on start.
- length  in  ADDR_W  number of words; latched on start; 0 = empty test.
- seed  in  DATA_W  pattern seed; latched on start.
- chipselect  out  1  asserted with every command.
- write_n  out  1  active-low write command.
- read_n  out  1  active-low read command.
- byteenable_n  out  2  always 2'b00 (both bytes enabled).
- address  out  ADDR_W  command word address.
- write_data  out  DATA_W  write payload.
- read_data  in  DATA_W  read return data.
- wait_request  in  1  slave stall.
- data_validation  in  1  read_data valid this cycle.
- busy  out  1  high in WRITE, READ and DRAIN.
- done  out  1  high in DONE; held until the next start.
- pass  out  1  valid when done; 1 iff err_count == 0 and proto_err == 0.
- err_count  out  16  mismatching words; saturates at 16'hFFFF.
- first_fail_addr  out  ADDR_W  address of the first mismatch.
- proto_err  out  1  sticky; data_validation seen with no read outstanding.

Behaviour:
- Reset (asynchronous, immediate, including mid-test):
  - State goes to IDLE.
  - chipselect=0, write_n=1, read_n=1, byteenable_n=2'b00, address=0, write_data=0.
  - busy=0, done=0, pass=0, err_count=0, first_fail_addr=0, proto_err=0.
  - Outstanding counter cleared.
- Pattern: word i (0-based) is at address base_addr+i, taken modulo 2^ADDR_W (wraps at top of memory). Its data is (base_addr+i)[15:0] XOR seed.
- Command handshake:
  - A command is registered output: chipselect=1 together with write_n=0 or read_n=0.
  - The command is accepted on the first rising edge where it is asserted and wait_request=0.
  - While wait_request=1 the command, address and write_data are held stable.
  - Back-to-back commands are allowed: a new command may be presented the cycle after acceptance.
  - Outputs are idle (chipselect=0, write_n=1, read_n=1) whenever no command is issued.
- State IDLE: on start, latch inputs, clear err_count, first_fail_addr, proto_err and done, then go to:
  - DONE if length==0;
  - WRITE otherwise.
- State WRITE: issue writes for i=0..length-1, one per accepted cycle. After the last write is accepted, go to READ. The write index and the read-issue index are separate counters.
- State READ:
  - Issue reads i=0..length-1.
  - Do not present a new read while outstanding==MAX_PENDING.
  - After the last read is accepted, go to DRAIN.
- State DRAIN: wait until outstanding==0, then go to DONE.
- State DONE: done=1; pass is valid; start returns to the latch step of IDLE behaviour (a new test begins).
- Outstanding counter:
  - +1 on read acceptance; −1 on data_validation.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_PENDING.
  - Never underflows: data_validation with outstanding==0 sets proto_err, is not decremented and is not compared.
- Compare:
  - Read data returns in issue order.
  - A separate return index k advances on every counted data_validation.
  - Expected value is (base_addr+k)[15:0] XOR seed.
  - On mismatch: err_count increments (saturating). If this is the first mismatch, first_fail_addr = base_addr+k.
- Timing:
  - Compare results are registered; err_count updates 1 cycle after data_validation.
  - done rises no earlier than 1 cycle after the final compare.
  - Pass latency with no stalls and fixed read latency L: about 2·length + L + 3 cycles.
- start while busy: ignored. An active command is never dropped or altered.

Test Plan:
1. Ideal slave, base=0, length=4, seed=16'h0000 → writes 0x0000..0x0003 to addr 0..3. Reads return the same data; done=1, pass=1, err_count=0.
2. wait_request held high 3 cycles on the second write, base=25'h100, seed=16'hA5A5 → address 25'h101 / data 16'hA4A4 held stable all 4 cycles. Exactly 4 writes accepted; pass=1.
3. Slave corrupts the word at addr 0x2 (returns 16'hFFFF), length=8 → err_count=1, first_fail_addr=0x2, pass=0.
4. Read latency 10, MAX_PENDING=7, length=20 → outstanding never exceeds 7 and read_n stalls at 7. All 20 reads compared; pass=1.
5. base=25'h1FFFFFE, length=4 → addresses 1FFFFFE, 1FFFFFF, 0000000, 0000001. Data follows the wrapped address XOR seed.
6. length=0 → DONE next cycle with pass=1 and no commands. Stray data_validation in IDLE → proto_err=1. reset_n pulsed low mid-READ → all outputs return to reset values immediately.
